gpio_interrupt_controller: RTL and testbench
============================================

Name: gpio_interrupt_controller

Overview:
Downstream of the per-pin GPIO cells. Collects the `interrupt_o` lines of GPIO_NUMBER GPIO instances and rising-edge detects them into sticky pending bits. Masks and arbitrates the pending bits, then presents a single vectored request to the CPU interrupt port using a request/acknowledge/complete handshake. Software-visible state is exposed through a small word-addressed register interface, in the same style as the GPIO cell.

Parameters:
GPIO_NUMBER, 8, number of GPIO interrupt sources; legal range 2..32.
VECTOR_WIDTH, $clog2(GPIO_NUMBER), width of the source index.

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous, active-high reset
gpio_interrupt_i  input  GPIO_NUMBER  interrupt_o of each GPIO cell; synchronous to clk_i
write_i  input  1  register write strobe
write_address_i  input  2  register write address
write_data_i  input  32  register write data
read_address_i  input  2  register read address
read_data_o  output  32  register read data; combinational
interrupt_o  output  1  request to CPU
interrupt_vector_o  output  VECTOR_WIDTH  index of the source being requested or serviced
interrupt_ack_i  input  1  CPU accepts the request
interrupt_done_i  input  1  CPU finished the service routine

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset values: pending=0, mask=0, enable=0, prev_irq=0, state=IDLE, interrupt_o=0, interrupt_vector_o=0.
- Edge detect: prev_irq <= gpio_interrupt_i every cycle. A rise (cur & ~prev) sets pending[i].
- Register map:
  - 0 PENDING: read returns pending; a write clears every bit written as 1 (W1C).
  - 1 MASK: RW. A bit set to 1 enables that source.
  - 2 STATUS: RO; writes are ignored. [VECTOR_WIDTH-1:0]=latched vector, [8]=state!=IDLE, [9]=state==SERVICE.
  - 3 CONTROL: RW. [0] is the global enable.
  - Unused read bits return 0.
- Simultaneous events on one pending bit: set (new edge) wins over W1C and over ack-clear.
- Eligible set: eligible = pending & mask & {GPIO_NUMBER{enable}}.
- FSM:
  - IDLE: if eligible != 0, latch the arbiter winner into vector and go to REQUEST.
  - REQUEST: interrupt_o=1. On interrupt_ack_i, clear pending[vector] and go to SERVICE. If eligible[vector] drops before ack (W1C, mask or disable), go back to IDLE with no clear.
  - SERVICE: interrupt_o=0. Wait for interrupt_done_i, then go to IDLE. New edges keep accumulating in pending.
- Outputs are registered from the state. interrupt_o = (state==REQUEST). interrupt_vector_o holds the latched vector in REQUEST and SERVICE.
- Latency: a rise sampled at edge k sets pending at edge k. interrupt_o is high after edge k+1 (two cycles from input change). Back-to-back requests need one IDLE cycle between them.
- Protocol violations: ack outside REQUEST is ignored; done outside SERVICE is ignored.
- Source held high: produces exactly one pending set, because it is edge triggered.
- Reset mid-operation: state returns to IDLE and all pending bits are lost.

Optional Feature:
- Macro: GPIO_IRQ_ROUND_ROBIN_EN.
- With the macro: the arbiter is round-robin. Search starts at (last granted vector + 1) mod GPIO_NUMBER, and the last-grant pointer is updated on every IDLE->REQUEST transition; reset value 0, so the first search starts at 1.
- Without the macro: fixed priority, lowest index wins, and the pointer logic is absent.

Decomposition:
- Package gpio_irq_pkg holds:
  - the FSM state enum `irq_state_t` {IDLE, REQUEST, SERVICE};
  - the address constants PENDING_ADDR=0, MASK_ADDR=1, STATUS_ADDR=2, CONTROL_ADDR=3;
  - the STATUS bit positions.
- Sub-module gpio_irq_arbiter: inputs eligible and the last pointer; outputs a winner index and a valid flag. It is purely combinational, and the round-robin macro applies inside it.

Test Plan:
- Reset then single rise: MASK=0x01, CONTROL=1, pulse gpio_interrupt_i[0] -> interrupt_o high two cycles later, vector=0. Ack -> PENDING=0x00, STATUS[9]=1. Done -> STATUS=0.
- Masked source: MASK=0x00, rise on bit 3 -> PENDING=0x08 and interrupt_o stays 0. Then write MASK=0x08 -> interrupt_o rises with vector=3.
- Priority: rises on bits 2 and 5 in the same cycle, fixed priority -> vector=2 first. After ack and done -> vector=5.
- Round-robin (macro defined): bits 1 and 2 kept re-pending every service -> grants alternate 1,2,1,2.
- Collision and withdrawal: W1C of bit 4 in the same cycle as a new rise on bit 4 -> pending[4] stays 1. During REQUEST for bit 4, write MASK=0 -> interrupt_o drops next cycle, FSM returns to IDLE, and pending[4] is still 1.
- Async reset during SERVICE: assert rst_i mid-cycle -> interrupt_o=0 and PENDING=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/gpio_irq_pkg.sv
// -----------------------------------------------------------------------------
// gpio_irq_pkg
// Types and constants shared by the GPIO interrupt controller and its arbiter:
//   irq_state_t           controller FSM state
//   *_ADDR                word addresses of the software register map
//   STATUS_*_BIT          bit positions inside the STATUS word
// -----------------------------------------------------------------------------
package gpio_irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam logic [1:0] PENDING_ADDR = 2'd0;
  localparam logic [1:0] MASK_ADDR    = 2'd1;
  localparam logic [1:0] STATUS_ADDR  = 2'd2;
  localparam logic [1:0] CONTROL_ADDR = 2'd3;

  // STATUS[VECTOR_WIDTH-1:0] carries the latched vector.
  localparam int STATUS_ACTIVE_BIT  = 8;
  localparam int STATUS_SERVICE_BIT = 9;

endpackage

// File: rtl/gpio_irq_arbiter.sv
// -----------------------------------------------------------------------------
// gpio_irq_arbiter
// Purely combinational pick of one eligible interrupt source.
// Build option: GPIO_IRQ_ROUND_ROBIN_EN
//   defined   -> round-robin, search starts at (last_i + 1) mod GPIO_NUMBER
//   undefined -> fixed priority, lowest index wins, last_i ignored
// Ports:
//   eligible_i  [GPIO_NUMBER]   sources allowed to request
//   last_i      [VECTOR_WIDTH]  most recently granted vector
//   winner_o    [VECTOR_WIDTH]  selected source index (0 when !valid_o)
//   valid_o                     at least one source is eligible
// -----------------------------------------------------------------------------
module gpio_irq_arbiter
  import gpio_irq_pkg::*;
#(
  parameter int GPIO_NUMBER  = 8,
  parameter int VECTOR_WIDTH = $clog2(GPIO_NUMBER)
) (
  input  logic [GPIO_NUMBER-1:0]  eligible_i,
  input  logic [VECTOR_WIDTH-1:0] last_i,
  output logic [VECTOR_WIDTH-1:0] winner_o,
  output logic                    valid_o
);

`ifdef GPIO_IRQ_ROUND_ROBIN_EN

  localparam logic [VECTOR_WIDTH:0] LAST_IDX = (VECTOR_WIDTH+1)'(GPIO_NUMBER - 1);
  localparam logic [VECTOR_WIDTH:0] ONE      = (VECTOR_WIDTH+1)'(1);

  logic [VECTOR_WIDTH:0]  rr_start;
  logic [GPIO_NUMBER-1:0] rr_rot;

  // Index arithmetic modulo GPIO_NUMBER, which need not be a power of two.
  function automatic logic [VECTOR_WIDTH-1:0] wrap_add(input logic [VECTOR_WIDTH:0] base,
                                                       input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= GPIO_NUMBER) sum = sum - GPIO_NUMBER;
    return VECTOR_WIDTH'(sum);
  endfunction

  assign rr_start = ({1'b0, last_i} >= LAST_IDX) ? '0 : {1'b0, last_i} + ONE;

  // Rotate so that bit 0 of rr_rot is the first source in search order.
  assign rr_rot = GPIO_NUMBER'({eligible_i, eligible_i} >> rr_start);

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    for (int i = 0; i < GPIO_NUMBER; i++) begin
      if (!valid_o && rr_rot[i]) begin
        valid_o  = 1'b1;
        winner_o = wrap_add(rr_start, i);
      end
    end
  end

`else

  logic unused_last;
  assign unused_last = ^last_i;

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    for (int i = 0; i < GPIO_NUMBER; i++) begin
      if (!valid_o && eligible_i[i]) begin
        valid_o  = 1'b1;
        winner_o = VECTOR_WIDTH'(i);
      end
    end
  end

`endif

endmodule

// File: rtl/gpio_interrupt_controller.sv
// -----------------------------------------------------------------------------
// gpio_interrupt_controller
// Rising-edge detects the interrupt lines of GPIO_NUMBER GPIO cells into sticky
// pending bits, masks and arbitrates them, and drives one vectored request to
// the CPU with a request / acknowledge / complete handshake.
// Build option: GPIO_IRQ_ROUND_ROBIN_EN selects round-robin arbitration
// (default build: fixed priority, lowest index first).
//
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   gpio_interrupt_i   [N]     interrupt_o of each GPIO cell (clk_i domain)
//   write_i                    register write strobe
//   write_address_i    [2]     register write address
//   write_data_i       [32]    register write data
//   read_address_i     [2]     register read address
//   read_data_o        [32]    register read data (combinational)
//   interrupt_o                request to CPU
//   interrupt_vector_o [VW]    source being requested / serviced
//   interrupt_ack_i            CPU accepts the request
//   interrupt_done_i           CPU finished the service routine
//
// Register map: 0 PENDING (W1C), 1 MASK (RW), 2 STATUS (RO), 3 CONTROL (RW, [0]=enable)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no request outstanding; arbitrate eligible sources
// REQUEST | interrupt_o high, waiting for ack or for the source to vanish
// SERVICE | CPU running the handler, waiting for done
// -----------------------------------------------------------------------------
module gpio_interrupt_controller
  import gpio_irq_pkg::*;
#(
  parameter int GPIO_NUMBER  = 8,
  parameter int VECTOR_WIDTH = $clog2(GPIO_NUMBER)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [GPIO_NUMBER-1:0]  gpio_interrupt_i,
  input  logic                    write_i,
  input  logic [1:0]              write_address_i,
  input  logic [31:0]             write_data_i,
  input  logic [1:0]              read_address_i,
  output logic [31:0]             read_data_o,
  output logic                    interrupt_o,
  output logic [VECTOR_WIDTH-1:0] interrupt_vector_o,
  input  logic                    interrupt_ack_i,
  input  logic                    interrupt_done_i
);

  logic [GPIO_NUMBER-1:0]  prev_irq_q;
  logic [GPIO_NUMBER-1:0]  pending_q, pending_d;
  logic [GPIO_NUMBER-1:0]  mask_q, mask_d;
  logic                    enable_q, enable_d;
  irq_state_t              state_q, state_d;
  logic [VECTOR_WIDTH-1:0] vector_q, vector_d;

  logic [GPIO_NUMBER-1:0]  rise;
  logic [GPIO_NUMBER-1:0]  eligible;
  logic [VECTOR_WIDTH-1:0] winner;
  logic                    winner_valid;
  logic [VECTOR_WIDTH-1:0] last_grant;
  logic                    ack_clear;
  logic [31:0]             status_word;

  logic unused_wdata;
  assign unused_wdata = ^write_data_i;

  assign rise     = gpio_interrupt_i & ~prev_irq_q;
  assign eligible = pending_q & mask_q & {GPIO_NUMBER{enable_q}};

  gpio_irq_arbiter #(
    .GPIO_NUMBER  (GPIO_NUMBER),
    .VECTOR_WIDTH (VECTOR_WIDTH)
  ) u_arbiter (
    .eligible_i (eligible),
    .last_i     (last_grant),
    .winner_o   (winner),
    .valid_o    (winner_valid)
  );

`ifdef GPIO_IRQ_ROUND_ROBIN_EN
  logic [VECTOR_WIDTH-1:0] rr_ptr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
    end else if (state_q == IDLE && winner_valid) begin
      rr_ptr_q <= winner;
    end
  end

  assign last_grant = rr_ptr_q;
`else
  assign last_grant = '0;
`endif

  // ------------------------------------------------------------------ FSM
  always_comb begin
    state_d   = state_q;
    vector_d  = vector_q;
    ack_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (winner_valid) begin
          vector_d = winner;
          state_d  = REQUEST;
        end
      end
      REQUEST: begin
        // An ack in the same cycle the source vanishes still counts: the CPU
        // already saw interrupt_o high and committed to the handler.
        if (interrupt_ack_i) begin
          ack_clear = 1'b1;
          state_d   = SERVICE;
        end else if (!eligible[vector_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (interrupt_done_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------------ registers
  always_comb begin
    pending_d = pending_q;
    mask_d    = mask_q;
    enable_d  = enable_q;
    if (write_i) begin
      unique case (write_address_i)
        PENDING_ADDR: pending_d = pending_q & ~write_data_i[GPIO_NUMBER-1:0];
        MASK_ADDR:    mask_d    = write_data_i[GPIO_NUMBER-1:0];
        CONTROL_ADDR: enable_d  = write_data_i[0];
        default:      ;
      endcase
    end
    if (ack_clear) pending_d[vector_q] = 1'b0;
    // New edges are applied last so they win over W1C and ack-clear.
    pending_d = pending_d | rise;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_irq_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      enable_q   <= 1'b0;
      state_q    <= IDLE;
      vector_q   <= '0;
    end else begin
      prev_irq_q <= gpio_interrupt_i;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      enable_q   <= enable_d;
      state_q    <= state_d;
      vector_q   <= vector_d;
    end
  end

  // -------------------------------------------------------------- outputs
  assign interrupt_o        = (state_q == REQUEST);
  assign interrupt_vector_o = vector_q;

  always_comb begin
    status_word                     = '0;
    status_word[VECTOR_WIDTH-1:0]   = vector_q;
    status_word[STATUS_ACTIVE_BIT]  = (state_q != IDLE);
    status_word[STATUS_SERVICE_BIT] = (state_q == SERVICE);
  end

  always_comb begin
    read_data_o = '0;
    unique case (read_address_i)
      PENDING_ADDR: read_data_o = 32'(pending_q);
      MASK_ADDR:    read_data_o = 32'(mask_q);
      STATUS_ADDR:  read_data_o = status_word;
      CONTROL_ADDR: read_data_o = {31'd0, enable_q};
      default:      read_data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_gpio_interrupt_controller.sv
module tb_gpio_interrupt_controller;

  localparam int N  = 8;
  localparam int VW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  gpio;
  logic          write_i;
  logic [1:0]    waddr;
  logic [31:0]   wdata;
  logic [1:0]    raddr;
  logic [31:0]   rdata;
  logic          irq;
  logic [VW-1:0] vec;
  logic          ack;
  logic          done;

  int vectors     = 0;
  int miscompares = 0;

  gpio_interrupt_controller #(.GPIO_NUMBER(N)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .gpio_interrupt_i   (gpio),
    .write_i            (write_i),
    .write_address_i    (waddr),
    .write_data_i       (wdata),
    .read_address_i     (raddr),
    .read_data_o        (rdata),
    .interrupt_o        (irq),
    .interrupt_vector_o (vec),
    .interrupt_ack_i    (ack),
    .interrupt_done_i   (done)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------- reference model
  localparam int M_IDLE = 0, M_REQ = 1, M_SVC = 2;

  bit [N-1:0] m_prev, m_pend, m_mask;
  bit         m_en;
  int         m_phase;
  int         m_vec;
  int         m_last;

  function automatic void model_reset();
    m_prev = '0; m_pend = '0; m_mask = '0; m_en = 1'b0;
    m_phase = M_IDLE; m_vec = 0; m_last = 0;
  endfunction

  function automatic int pick(input bit [N-1:0] elig);
`ifdef GPIO_IRQ_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) if (elig[(m_last + k) % N]) return (m_last + k) % N;
`else
    for (int k = 0; k < N; k++) if (elig[k]) return k;
`endif
    return 0;
  endfunction

  function automatic void model_step();
    bit [N-1:0] rises, elig, np;
    int nphase;
    rises  = gpio & ~m_prev;
    elig   = m_en ? (m_pend & m_mask) : '0;
    np     = m_pend;
    nphase = m_phase;
    if (write_i && waddr == 2'd0) np = np & ~wdata[N-1:0];
    if (m_phase == M_IDLE) begin
      if (elig != 0) begin
        m_vec  = pick(elig);
        m_last = m_vec;
        nphase = M_REQ;
      end
    end else if (m_phase == M_REQ) begin
      if (ack) begin
        np[m_vec] = 1'b0;
        nphase    = M_SVC;
      end else if (!elig[m_vec]) begin
        nphase = M_IDLE;
      end
    end else if (done) begin
      nphase = M_IDLE;
    end
    np = np | rises;
    if (write_i && waddr == 2'd1) m_mask = wdata[N-1:0];
    if (write_i && waddr == 2'd3) m_en   = wdata[0];
    m_pend  = np;
    m_phase = nphase;
    m_prev  = gpio;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_pend);
      2'd1:    return 32'(m_mask);
      2'd2:    return 32'(m_vec) | ((m_phase != M_IDLE) ? 32'h100 : 32'h0)
                                 | ((m_phase == M_SVC)  ? 32'h200 : 32'h0);
      default: return {31'd0, m_en};
    endcase
  endfunction

  // ------------------------------------------------------------------- helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    check("irq", 32'(irq), (m_phase == M_REQ) ? 32'd1 : 32'd0);
    check("vector", 32'(vec), 32'(m_vec));
  endtask

  task automatic rd(input logic [1:0] a);
    raddr = a;
    #1;
    check($sformatf("read[%0d]", a), rdata, model_read(a));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    write_i = 1'b1; waddr = a; wdata = d;
    tick();
    write_i = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1; tick(); done = 1'b0;
  endtask

  // ------------------------------------------------------------------ stimulus
  int exp_first, exp_second;

  initial begin
    rst = 1'b1; gpio = '0; write_i = 1'b0; waddr = '0; wdata = '0;
    raddr = '0; ack = 1'b0; done = 1'b0;
    model_reset();
    #12 rst = 1'b0;

    // reset state
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_vec", 32'(vec), 32'd0);
    for (int a = 0; a < 4; a++) rd(2'(a));

    // single rise on bit 0
    wr(2'd1, 32'h01);
    wr(2'd3, 32'h01);
    gpio[0] = 1'b1;
    tick();
    check("t1_irq_early", 32'(irq), 32'd0);
    tick();
    check("t1_irq", 32'(irq), 32'd1);
    check("t1_vec", 32'(vec), 32'd0);
    gpio = '0;
    pulse_ack();
    raddr = 2'd0; #1 check("t1_pending", rdata, 32'h00);
    raddr = 2'd2; #1 check("t1_status_svc", rdata, 32'h300);
    pulse_done();
    raddr = 2'd2; #1 check("t1_status_idle", rdata, 32'h000);

    // masked source, then unmask
    wr(2'd1, 32'h00);
    gpio[3] = 1'b1;
    tick();
    gpio = '0;
    tick();
    raddr = 2'd0; #1 check("t2_pending", rdata, 32'h08);
    check("t2_irq_masked", 32'(irq), 32'd0);
    wr(2'd1, 32'h08);
    tick();
    check("t2_irq", 32'(irq), 32'd1);
    check("t2_vec", 32'(vec), 32'd3);
    pulse_ack();
    pulse_done();

    // two sources in the same cycle
`ifdef GPIO_IRQ_ROUND_ROBIN_EN
    exp_first = 5; exp_second = 2;
`else
    exp_first = 2; exp_second = 5;
`endif
    wr(2'd1, 32'hFF);
    gpio = 8'h24;
    tick();
    gpio = '0;
    tick();
    check("t3_vec_first", 32'(vec), 32'(exp_first));
    pulse_ack();
    pulse_done();
    tick();
    check("t3_irq_second", 32'(irq), 32'd1);
    check("t3_vec_second", 32'(vec), 32'(exp_second));
    pulse_ack();
    pulse_done();

    // W1C collides with a new edge, then withdrawal by mask
    wr(2'd1, 32'h10);
    gpio[4] = 1'b1;
    wr(2'd0, 32'h10);
    rd(2'd0);
    raddr = 2'd0; #1 check("t4_pending_kept", rdata, 32'h10);
    tick();
    check("t4_vec", 32'(vec), 32'd4);
    gpio = '0;
    wr(2'd1, 32'h00);
    check("t4_irq_still", 32'(irq), 32'd1);
    tick();
    check("t4_irq_dropped", 32'(irq), 32'd0);
    raddr = 2'd0; #1 check("t4_pending_after", rdata, 32'h10);
    raddr = 2'd2; #1 check("t4_status", rdata, 32'h004);

    // asynchronous reset while in SERVICE
    wr(2'd0, 32'hFF);
    wr(2'd1, 32'h10);
    gpio = 8'h50;
    tick();
    gpio = '0;
    tick();
    pulse_ack();
    raddr = 2'd2; #1 check("t5_status_svc", rdata, 32'h304);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("t5_irq_async", 32'(irq), 32'd0);
    raddr = 2'd0; #1 check("t5_pending_async", rdata, 32'h00);
    rst = 1'b0;
    tick();

`ifdef GPIO_IRQ_ROUND_ROBIN_EN
    // round-robin alternation between two sources that keep re-pending
    begin
      int exp_rr[4] = '{1, 2, 1, 2};
      wr(2'd1, 32'h06);
      wr(2'd3, 32'h01);
      gpio = 8'h06;
      tick();
      gpio = '0;
      tick();
      for (int g = 0; g < 4; g++) begin
        check($sformatf("rr_grant%0d", g), 32'(vec), 32'(exp_rr[g]));
        pulse_ack();
        gpio = N'(1) << exp_rr[g];
        tick();
        gpio = '0;
        pulse_done();
        tick();
      end
      wr(2'd0, 32'hFF);
    end
`endif

    // randomized traffic against the model
    wr(2'd1, 32'hFF);
    wr(2'd3, 32'h01);
    for (int c = 0; c < 800; c++) begin
      gpio    = gpio ^ N'($urandom & $urandom & $urandom);
      write_i = ($urandom_range(0, 4) == 0);
      waddr   = 2'($urandom_range(0, 3));
      wdata   = $urandom;
      if (waddr == 2'd3 && $urandom_range(0, 3) != 0) wdata[0] = 1'b1;
      ack     = ($urandom_range(0, 2) == 0);
      done    = ($urandom_range(0, 3) == 0);
      tick();
      write_i = 1'b0;
      rd(2'($urandom_range(0, 3)));
    end
    ack = 1'b0; done = 1'b0; gpio = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
